// File: rtl/layer_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_result_collector_if
// Purpose  : Bundles the neuron write stream, argmax request/response and
//            result handshake seen by layer_result_collector.
//            master = collector side, slave = surrounding environment.
// Revision : 1.0  initial release
// ============================================================================
interface layer_result_collector_if #(
  parameter int N_OUT   = 10,
  parameter int DATA_W  = 16,
  parameter int DIGIT_W = 8
) ();
  // neuron write stream
  logic                      nrn_valid;
  logic [DIGIT_W-1:0]        nrn_idx;
  logic [DATA_W-1:0]         nrn_data;
  logic                      nrn_ready;
  // argmax unit request / response
  logic                      sm_enable;
  logic [N_OUT*DATA_W-1:0]   sm_data;
  logic                      sm_layer_done;
  logic [DIGIT_W-1:0]        sm_digit;
  logic [DATA_W-1:0]         sm_max;
  // result handshake
  logic                      res_valid;
  logic                      res_ready;
  logic [DIGIT_W-1:0]        res_digit;
  logic [DATA_W-1:0]         res_max;
  // sticky error flags
  logic                      err_idx;
  logic                      err_timeout;
  logic                      err_mismatch;

  modport master (
    input  nrn_valid, nrn_idx, nrn_data,
    output nrn_ready,
    output sm_enable, sm_data,
    input  sm_layer_done, sm_digit, sm_max,
    output res_valid, res_digit, res_max,
    input  res_ready,
    output err_idx, err_timeout, err_mismatch
  );

  modport slave (
    output nrn_valid, nrn_idx, nrn_data,
    input  nrn_ready,
    input  sm_enable, sm_data,
    output sm_layer_done, sm_digit, sm_max,
    input  res_valid, res_digit, res_max,
    output res_ready,
    input  err_idx, err_timeout, err_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/layer_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : layer_result_collector
// Purpose  : Packs the final layer's neuron outputs into a vector, requests an
//            argmax from the argmax unit and presents {digit,max} downstream
//            over a valid/ready handshake.
// Options  : ARGMAX_CHECK_EN - when defined, the returned digit/max is checked
//            against the collected vector and err_mismatch is raised on error.
// Revision : 1.0  initial release
// ============================================================================
module layer_result_collector #(
  parameter int N_OUT       = 10,
  parameter int DATA_W      = 16,
  parameter int DIGIT_W     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,   // synchronous, active-low
  layer_result_collector_if.master bus
);

  localparam logic [1:0] c_ST_COLLECT = 2'd0;
  localparam logic [1:0] c_ST_REQUEST = 2'd1;
  localparam logic [1:0] c_ST_RESULT  = 2'd2;

  localparam int                 c_CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [N_OUT-1:0]   c_MASK_FULL = '1;

  logic [1:0]              r_state;
  logic [N_OUT-1:0]        r_mask;
  logic [N_OUT*DATA_W-1:0] r_data;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [DIGIT_W-1:0]      r_res_digit;
  logic [DATA_W-1:0]       r_res_max;
  logic                    r_err_idx;
  logic                    r_err_timeout;

  logic                    w_wr;
  logic                    w_idx_ok;
  logic [N_OUT-1:0]        w_mask_set;
  logic [N_OUT-1:0]        w_mask_next;
  logic                    w_capture;

  assign w_wr        = bus.nrn_valid && (r_state == c_ST_COLLECT);
  assign w_idx_ok    = bus.nrn_idx < DIGIT_W'(N_OUT);
  assign w_mask_next = r_mask | w_mask_set;
  assign w_capture   = (r_state == c_ST_REQUEST) && bus.sm_layer_done;

  // One-hot decode of the accepted write index; out-of-range indices hit nothing
  always_comb begin
    w_mask_set = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_wr && (bus.nrn_idx == DIGIT_W'(i))) begin
        w_mask_set[i] = 1'b1;
      end
    end
  end

  // Main FSM: collect vector, hold request until done or timeout, hand off result
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= c_ST_COLLECT;
      r_mask        <= '0;
      r_data        <= '0;
      r_cnt         <= '0;
      r_res_digit   <= '0;
      r_res_max     <= '0;
      r_err_idx     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_ST_COLLECT: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (w_mask_set[i]) begin
              r_data[i*DATA_W +: DATA_W] <= bus.nrn_data;
            end
          end
          r_mask <= w_mask_next;
          if (w_wr && !w_idx_ok) begin
            r_err_idx <= 1'b1;
          end
          if (w_mask_next == c_MASK_FULL) begin
            r_state <= c_ST_REQUEST;
          end
        end
        c_ST_REQUEST: begin
          if (bus.sm_layer_done) begin
            r_res_digit <= bus.sm_digit;
            r_res_max   <= bus.sm_max;
            r_state     <= c_ST_RESULT;
          end else if (r_cnt == c_CNT_LAST) begin
            // abort: deliver a recognisable "no answer" result
            r_err_timeout <= 1'b1;
            r_res_digit   <= '1;
            r_res_max     <= '0;
            r_state       <= c_ST_RESULT;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_RESULT: begin
          if (bus.res_ready) begin
            r_mask  <= '0;
            r_cnt   <= '0;
            r_state <= c_ST_COLLECT;
          end
        end
        default: begin
          r_state <= c_ST_COLLECT;
        end
      endcase
    end
  end

`ifdef ARGMAX_CHECK_EN
  logic w_hit_ok;
  logic w_over;
  logic r_err_mismatch;

  // Returned digit must point at an element equal to max, and no element may exceed max
  always_comb begin
    w_hit_ok = 1'b0;
    w_over   = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if ((bus.sm_digit == DIGIT_W'(i)) && (r_data[i*DATA_W +: DATA_W] == bus.sm_max)) begin
        w_hit_ok = 1'b1;
      end
      if ($signed(r_data[i*DATA_W +: DATA_W]) > $signed(bus.sm_max)) begin
        w_over = 1'b1;
      end
    end
  end

  // Sticky mismatch flag, evaluated only on the capture edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err_mismatch <= 1'b0;
    end else if (w_capture && (!w_hit_ok || w_over)) begin
      r_err_mismatch <= 1'b1;
    end
  end

  assign bus.err_mismatch = r_err_mismatch;
`else
  assign bus.err_mismatch = 1'b0;
`endif

  assign bus.nrn_ready   = (r_state == c_ST_COLLECT);
  assign bus.sm_enable   = (r_state == c_ST_REQUEST);
  assign bus.res_valid   = (r_state == c_ST_RESULT);
  assign bus.sm_data     = r_data;
  assign bus.res_digit   = r_res_digit;
  assign bus.res_max     = r_res_max;
  assign bus.err_idx     = r_err_idx;
  assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_layer_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_result_collector
// Purpose  : Self-checking bench for layer_result_collector. A behavioural
//            model (vector array, written-index set, sticky error bits) tracks
//            expected outputs; the bench itself plays the argmax unit.
// Options  : ARGMAX_CHECK_EN - mirrors the design option for err_mismatch.
// Revision : 1.0  initial release
// ============================================================================
module tb_layer_result_collector;

  localparam int N_OUT       = 10;
  localparam int DATA_W      = 16;
  localparam int DIGIT_W     = 8;
  localparam int TIMEOUT_CYC = 1024;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  layer_result_collector_if #(.N_OUT(N_OUT), .DATA_W(DATA_W), .DIGIT_W(DIGIT_W)) ifc ();

  layer_result_collector #(
    .N_OUT(N_OUT), .DATA_W(DATA_W), .DIGIT_W(DIGIT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  // behavioural model
  logic signed [15:0] m_vec [N_OUT];
  bit                 m_mask[N_OUT];
  bit                 m_err_idx, m_err_to, m_err_mm;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] m_packed();
    logic [159:0] v = '0;
    for (int i = 0; i < N_OUT; i++) v[i*16 +: 16] = m_vec[i];
    return v;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N_OUT; i++) if (!m_mask[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_argmax();
    int best = 0;
    for (int i = 1; i < N_OUT; i++) if (m_vec[i] > m_vec[best]) best = i;
    return best;
  endfunction

  // true when the reported (digit,max) is not a valid argmax of the model vector
  function automatic bit m_bad_answer(input int dg, input logic signed [15:0] mx);
    if (dg >= N_OUT) return 1'b1;
    if (m_vec[dg] != mx) return 1'b1;
    for (int i = 0; i < N_OUT; i++) if (m_vec[i] > mx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_OUT; i++) begin
      m_vec[i]  = '0;
      m_mask[i] = 1'b0;
    end
    m_err_idx = 0; m_err_to = 0; m_err_mm = 0;
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_idx"},      ifc.err_idx,      m_err_idx);
    check({tag, "_err_timeout"},  ifc.err_timeout,  m_err_to);
    check({tag, "_err_mismatch"}, ifc.err_mismatch, m_err_mm);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_nrn_ready"}, ifc.nrn_ready, 1'b1);
    check({tag, "_sm_enable"}, ifc.sm_enable, 1'b0);
    check({tag, "_res_valid"}, ifc.res_valid, 1'b0);
    check({tag, "_res_digit"}, ifc.res_digit, 8'h00);
    check({tag, "_res_max"},   ifc.res_max,   16'h0000);
    check({tag, "_sm_data"},   ifc.sm_data,   160'h0);
    check_errs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    model_clear();
    check_reset_state("reset");
    reset = 1'b1;
  endtask

  // one neuron write; sm_enable must follow the model's "all written" state
  task automatic write(input int idx, input logic [15:0] d);
    check("nrn_ready_collect", ifc.nrn_ready, 1'b1);
    ifc.nrn_valid = 1'b1;
    ifc.nrn_idx   = idx[7:0];
    ifc.nrn_data  = d;
    tick();
    ifc.nrn_valid = 1'b0;
    if (idx < N_OUT) begin
      m_vec[idx]  = d;
      m_mask[idx] = 1'b1;
    end else begin
      m_err_idx = 1'b1;
    end
    check("sm_enable_vs_filled", ifc.sm_enable, m_full());
    check("err_idx", ifc.err_idx, m_err_idx);
  endtask

  // idle cycles in COLLECT with spurious layer_done pulses that must be ignored
  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      ifc.sm_layer_done = $urandom_range(0, 1) != 0;
      tick();
      ifc.sm_layer_done = 1'b0;
      check("gap_no_request", ifc.sm_enable, 1'b0);
    end
  endtask

  task automatic fill_vec(input logic [15:0] v [N_OUT], input bit descending, input int max_gap);
    for (int k = 0; k < N_OUT; k++) begin
      int i = descending ? N_OUT - 1 - k : k;
      write(i, v[i]);
      if (k != N_OUT - 1) gap($urandom_range(0, max_gap));
    end
  endtask

  // random order, random data, with duplicates and out-of-range writes mixed in
  task automatic fill_random();
    int perm[N_OUT];
    for (int i = 0; i < N_OUT; i++) perm[i] = i;
    for (int i = N_OUT - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (k > 0 && $urandom_range(0, 3) == 0)
        write(perm[$urandom_range(0, k - 1)], 16'($urandom));
      if ($urandom_range(0, 7) == 0)
        write($urandom_range(N_OUT, 255), 16'($urandom));
      write(perm[k], 16'($urandom));
      if (k != N_OUT - 1) gap($urandom_range(0, 2));
    end
  endtask

  // RESULT phase: hold res_ready low for 'hold' cycles, then complete the handshake
  task automatic finish_result(input int hold, input logic [7:0] dg, input logic [15:0] mx);
    ifc.res_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_res_valid", ifc.res_valid, 1'b1);
      check("hold_res_digit", ifc.res_digit, dg);
      check("hold_res_max",   ifc.res_max,   mx);
      check("hold_nrn_ready", ifc.nrn_ready, 1'b0);
    end
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;
    for (int i = 0; i < N_OUT; i++) m_mask[i] = 1'b0;
    check("post_res_valid", ifc.res_valid, 1'b0);
    check("post_nrn_ready", ifc.nrn_ready, 1'b1);
    check("post_sm_data_kept", ifc.sm_data, m_packed());
  endtask

  // play the argmax unit: answer (dg,mx) after 'delay' cycles, stray writes meanwhile
  task automatic serve(input int delay, input logic [7:0] dg, input logic [15:0] mx, input int hold);
    check("req_sm_enable", ifc.sm_enable, 1'b1);
    check("req_nrn_ready", ifc.nrn_ready, 1'b0);
    check("req_sm_data",   ifc.sm_data,   m_packed());
    for (int k = 0; k < delay; k++) begin
      ifc.nrn_valid = 1'b1;
      ifc.nrn_idx   = 8'($urandom_range(0, N_OUT - 1));
      ifc.nrn_data  = 16'($urandom);
      tick();
      ifc.nrn_valid = 1'b0;
      check("wait_sm_enable", ifc.sm_enable, 1'b1);
      check("wait_res_valid", ifc.res_valid, 1'b0);
      check("wait_sm_data",   ifc.sm_data,   m_packed());
    end
    ifc.sm_layer_done = 1'b1;
    ifc.sm_digit      = dg;
    ifc.sm_max        = mx;
    tick();
    ifc.sm_layer_done = 1'b0;
    ifc.sm_digit      = 8'($urandom);
    ifc.sm_max        = 16'($urandom);
`ifdef ARGMAX_CHECK_EN
    if (m_bad_answer(int'(dg), mx)) m_err_mm = 1'b1;
`endif
    check("cap_res_valid", ifc.res_valid, 1'b1);
    check("cap_sm_enable", ifc.sm_enable, 1'b0);
    check("cap_res_digit", ifc.res_digit, dg);
    check("cap_res_max",   ifc.res_max,   mx);
    check_errs("cap");
    finish_result(hold, dg, mx);
  endtask

  logic [15:0] vec [N_OUT];

  initial begin
    reset = 1'b0;
    ifc.nrn_valid = 1'b0; ifc.nrn_idx = '0; ifc.nrn_data = '0;
    ifc.sm_layer_done = 1'b0; ifc.sm_digit = '0; ifc.sm_max = '0;
    ifc.res_ready = 1'b0;
    tick();
    do_reset();

    // basic vector, ascending writes, fastest turnaround
    vec = '{16'd0, 16'd0, 16'd5, 16'd85, 16'd0, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0};
    fill_vec(vec, 1'b0, 0);
    serve(2, 8'd3, 16'd85, 0);

    // same vector, descending with gaps
    fill_vec(vec, 1'b1, 3);
    serve(0, 8'd3, 16'd85, 0);

    // bad index, duplicate overwrite, then the rest; result held 5 cycles
    write(12, 16'd1);
    write(3, 16'd20);
    write(3, 16'hFFF9);
    for (int i = 0; i < N_OUT; i++) if (i != 3) write(i, 16'd0);
    check("dup_overwrite_elem3", ifc.sm_data[63:48], 16'hFFF9);
    serve(1, 8'(m_argmax()), m_vec[m_argmax()], 5);

    // randomized layers against the model
    for (int r = 0; r < 8; r++) begin
      fill_random();
      serve($urandom_range(0, 6), 8'(m_argmax()), m_vec[m_argmax()], $urandom_range(0, 3));
    end

    // negative vector: correct answer, then an inconsistent one
    vec = '{16'hFFFD, 16'hFFFF, 16'hFFF8, 16'hFFF6, 16'hFFF6,
            16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6};
    fill_vec(vec, 1'b0, 1);
    serve(1, 8'd1, 16'hFFFF, 0);
    fill_vec(vec, 1'b0, 1);
    serve(1, 8'd0, 16'hFFFD, 0);

    // timeout: argmax unit never answers
    fill_random();
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) tick();
    check("to_not_early_enable", ifc.sm_enable, 1'b1);
    check("to_not_early_valid",  ifc.res_valid, 1'b0);
    tick();
    m_err_to = 1'b1;
    check("to_res_valid", ifc.res_valid, 1'b1);
    check("to_sm_enable", ifc.sm_enable, 1'b0);
    check("to_res_digit", ifc.res_digit, 8'hFF);
    check("to_res_max",   ifc.res_max,   16'h0000);
    check_errs("to");
    finish_result(2, 8'hFF, 16'h0000);

    // reset asserted in the middle of REQUEST
    fill_random();
    tick(); tick(); tick();
    check("pre_reset_enable", ifc.sm_enable, 1'b1);
    do_reset();

    // a layer after reset still works
    fill_random();
    serve(3, 8'(m_argmax()), m_vec[m_argmax()], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
